mult_div_unit: RTL and testbench

Iterative signed 32-bit multiply/divide unit in the execute stage, beside the single-cycle ALU. Consumes the two register-file operands of a `mul` or `div` R-type instruction and produces a 32-bit result plus exception flag. The processor stalls on `data_resultRDY` and writes the result to `rd`, or writes 1 to `$r30` on exception.

---
 rtl/multdiv_pkg.sv | 10 +
 rtl/signed_magnitude.sv | 13 +
 rtl/mult_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} md_state_e;

   localparam int unsigned MD_ITERS      = 32;
   localparam logic [31:0] MD_INT_MIN    = 32'h8000_0000;
   localparam logic [31:0] MD_ERR_RESULT = 32'h0;

endpackage

// File: rtl/signed_magnitude.sv
// Combinational two's-complement conditional negate; with neg_i tied to the sign bit it
// yields the absolute value.
module signed_magnitude #(
   parameter int unsigned Width = 32
) (
   input  logic [Width-1:0] value_i,
   input  logic             neg_i,
   output logic [Width-1:0] result_o
);

   assign result_o = neg_i ? (~value_i + Width'(1)) : value_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (shift-add) and divide (restoring), one bit per cycle.
// Define MULTDIV_DIV_EN to build the divider; otherwise every divide request reports an exception.
module mult_div_unit
   import multdiv_pkg::*;
#(
   parameter int unsigned WIDTH = MD_ITERS
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int unsigned     CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mag_q, mag_d;
   logic               sign_q, sign_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               exc_q, exc_d;
   logic               go_err;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mult_sum;
   logic [2*WIDTH-1:0] mult_next, res_mag, res_signed;
   logic               res_ovf;

   signed_magnitude #(.Width(WIDTH)) u_abs_a (
      .value_i (data_operandA),
      .neg_i   (data_operandA[WIDTH-1]),
      .result_o(a_mag)
   );

   signed_magnitude #(.Width(WIDTH)) u_abs_b (
      .value_i (data_operandB),
      .neg_i   (data_operandB[WIDTH-1]),
      .result_o(b_mag)
   );

   // acc = {partial product high, multiplier}; add multiplicand on lsb, then shift right.
   assign mult_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
   assign mult_next = {mult_sum, acc_q[WIDTH-1:1]};

`ifdef MULTDIV_DIV_EN
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;

   // acc = {remainder, dividend/quotient}; shift left and try subtracting the divisor.
   assign div_diff = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mag_q};
   assign div_next = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   assign res_mag  = (state_q == DIV) ? {{WIDTH{1'b0}}, div_next[WIDTH-1:0]} : mult_next;
`else
   assign res_mag  = mult_next;
`endif

   signed_magnitude #(.Width(2 * WIDTH)) u_sign_fix (
      .value_i (res_mag),
      .neg_i   (sign_q),
      .result_o(res_signed)
   );

   // Also covers INT_MIN / -1, whose positive quotient does not fit in WIDTH bits.
   assign res_ovf = res_signed != {{WIDTH{res_signed[WIDTH-1]}}, res_signed[WIDTH-1:0]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mag_d    = mag_q;
      sign_d   = sign_q;
      result_d = result_q;
      exc_d    = exc_q;
      go_err   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ctrl_MULT && ctrl_DIV) begin
               go_err = 1'b1;
            end else if (ctrl_MULT) begin
               state_d = MULT;
               acc_d   = {{WIDTH{1'b0}}, b_mag};
               mag_d   = a_mag;
               sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
               if (data_operandB == '0) begin
                  go_err = 1'b1;
               end else begin
                  state_d = DIV;
                  acc_d   = {{WIDTH{1'b0}}, a_mag};
                  mag_d   = b_mag;
                  sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
               end
`else
               go_err = 1'b1;
`endif
            end
         end
         MULT: begin
            acc_d = mult_next;
            if (cnt_q == CNT_LAST) begin
               cnt_d    = '0;
               state_d  = DONE;
               result_d = res_signed[WIDTH-1:0];
               exc_d    = res_ovf;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DIV: begin
`ifdef MULTDIV_DIV_EN
            acc_d = div_next;
            if (cnt_q == CNT_LAST) begin
               cnt_d    = '0;
               state_d  = DONE;
               result_d = res_signed[WIDTH-1:0];
               exc_d    = res_ovf;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`else
            state_d = IDLE;
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (go_err) begin
         state_d  = DONE;
         result_d = WIDTH'(MD_ERR_RESULT);
         exc_d    = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mag_q    <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mag_q    <= mag_d;
         sign_q   <= sign_d;
         result_q <= result_d;
         exc_q    <= exc_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state_q == DONE);
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors push expected results, a negedge
// monitor pops and checks them whenever data_resultRDY is seen.
module tb_mult_div_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   mult_div_unit #(.WIDTH(32)) dut (
      .clock         (clock),
      .reset         (reset),
      .ctrl_MULT     (ctrl_MULT),
      .ctrl_DIV      (ctrl_DIV),
      .data_operandA (data_operandA),
      .data_operandB (data_operandB),
      .data_result   (data_result),
      .data_exception(data_exception),
      .data_resultRDY(data_resultRDY),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        exc;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

`ifdef MULTDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (data_resultRDY === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_rdy got rdy 1 want 0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_result"}, data_result, e.res);
            check({e.name, "_exc"}, 32'(data_exception), 32'(e.exc));
            check({e.name, "_cycle"}, cyc, e.due);
         end
      end
   end

   task automatic run_op(input string name, input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic exc,
                         input int lat);
      exp_t e;
      int   t;
      int   bad;
      @(posedge clock); #1;
      ctrl_MULT = m;
      ctrl_DIV = d;
      data_operandA = a;
      data_operandB = b;
      t = cyc;
      e.name = name;
      e.res = res;
      e.exc = exc;
      e.due = t + lat;
      sb.push_back(e);
      @(negedge clock);
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
      @(posedge clock); #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = 32'hDEAD_BEEF;
      data_operandB = 32'h1234_5678;
      bad = 0;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clock);
         if (busy !== 1'b1) bad++;
      end
      check({name, "_busy_cycles_low"}, bad, 0);
   endtask

   task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic exc, input int lat);
      run_op(name, 1'b0, 1'b1, a, b, DIV_EN ? res : 32'h0, DIV_EN ? exc : 1'b1,
             DIV_EN ? lat : 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int t;
      exp_t e;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_result", data_result, 32'h0);
      check("reset_exc", 32'(data_exception), 32'd0);
      check("reset_rdy", 32'(data_resultRDY), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      run_op("mul_5x3",     1, 0, 32'd5,        32'd3,        32'h0000_000F, 0, 33);
      run_op("mul_m7x6",    1, 0, 32'hFFFF_FFF9, 32'd6,       32'hFFFF_FFD6, 0, 33);
      run_op("mul_ovf",     1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 33);
      run_op("mul_m1xm1",   1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 33);
      run_op("mul_minx1",   1, 0, 32'h8000_0000, 32'd1,       32'h8000_0000, 0, 33);
      run_op("mul_minxm1",  1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 33);
      run_op("mul_sq",      1, 0, 32'h0000_B505, 32'h0000_B505, 32'h8000_1219, 1, 33);
      run_op("mul_zero",    1, 0, 32'h0,        32'hFFFF_FFF9, 32'h0,        0, 33);
      run_op("both_ctrl",   1, 1, 32'd5,        32'd3,        32'h0,        1, 1);
      run_div("div_100_m7", 32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, 33);
      run_div("div_m100_7", 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 0, 33);
      run_div("div_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 0, 33);
      run_div("div_7_100",  32'd7,        32'd100,      32'h0,        0, 33);
      run_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 33);
      run_div("div_min_2",  32'h8000_0000, 32'd2,        32'hC000_0000, 0, 33);
      run_div("div_7_0",    32'd7,        32'd0,        32'h0,        1, 1);

      // Starts while busy must be ignored; only the 5x3 result may appear.
      @(posedge clock); #1;
      ctrl_MULT = 1'b1;
      data_operandA = 32'd5;
      data_operandB = 32'd3;
      t = cyc;
      e.name = "ign_start";
      e.res = 32'd15;
      e.exc = 1'b0;
      e.due = t + 33;
      sb.push_back(e);
      @(posedge clock); #1;
      ctrl_MULT = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      ctrl_MULT = 1'b1;
      data_operandA = 32'd100;
      data_operandB = 32'd100;
      @(posedge clock); #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b1;
      @(posedge clock); #1;
      ctrl_DIV = 1'b0;
      while (cyc <= t + 34) @(posedge clock);

      run_op("mul_max2",    1, 0, 32'h7FFF_FFFF, 32'd2,       32'hFFFF_FFFE, 1, 33);
      repeat (4) @(negedge clock);
      check("hold_result", data_result, 32'hFFFF_FFFE);
      check("hold_exc", 32'(data_exception), 32'd1);

      // Reset mid-operation aborts with no completion pulse.
      @(posedge clock); #1;
      ctrl_MULT = 1'b1;
      data_operandA = 32'd9;
      data_operandB = 32'd9;
      t = cyc;
      @(posedge clock); #1;
      ctrl_MULT = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      ctrl_DIV = 1'b1;
      @(posedge clock); #1;
      ctrl_DIV = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("abort_cycle", cyc, t + 11);
      check("abort_result", data_result, 32'h0);
      check("abort_exc", 32'(data_exception), 32'd0);
      check("abort_rdy", 32'(data_resultRDY), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);

      run_op("mul_2x3",     1, 0, 32'd2,        32'd3,        32'd6,        0, 33);

      repeat (40) @(posedge clock);
      check("sb_leftover", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
